// File: rtl/cache_pkg.sv
// Shared types for the instruction cache: controller states and BurstRAM command codes.
package cache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_REQ,
        S_FILL,
        S_DELIVER
    } state_t;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

endpackage

// File: rtl/cache_line_ram.sv
// Line data store: writes one whole BurstRAM beat per cycle, reads one word combinationally.
module cache_line_ram #(
    parameter int LINE_IX_W = 1,
    parameter int WORD_IX_W = 3,
    parameter int WORD_W    = 32,
    parameter int BEAT_W    = 64
) (
    input  logic                                   clk,
    input  logic                                   i_we,
    input  logic [LINE_IX_W-1:0]                   i_wr_line,
    input  logic [WORD_IX_W-$clog2(BEAT_W/WORD_W)-1:0] i_wr_beat,
    input  logic [BEAT_W-1:0]                      i_wr_data,
    input  logic [LINE_IX_W-1:0]                   i_rd_line,
    input  logic [WORD_IX_W-1:0]                   i_rd_word,
    output logic [WORD_W-1:0]                      o_rd_data
);

    localparam int WPB_W     = $clog2(BEAT_W / WORD_W);
    localparam int BEAT_IX_W = WORD_IX_W - WPB_W;

    // One entry per beat; word 2k lands in the low half of beat k.
    logic [BEAT_W-1:0] r_mem [2**(LINE_IX_W+BEAT_IX_W)];
    logic [BEAT_W-1:0] w_entry;
    logic [WPB_W-1:0]  w_sel;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[{i_wr_line, i_wr_beat}] <= i_wr_data;
        end
    end

    always_comb begin
        w_entry   = r_mem[{i_rd_line, i_rd_word[WORD_IX_W-1:WPB_W]}];
        w_sel     = i_rd_word[WPB_W-1:0];
        o_rd_data = w_entry[w_sel*WORD_W +: WORD_W];
    end

endmodule

// File: rtl/cache.sv
// Direct-mapped instruction cache in front of a BurstRAM; port A is reserved.
// Define CACHE_DBG_EN to log hits, misses and completed fills.
module cache
    import cache_pkg::*;
#(
    parameter int ADDRESS_BITWIDTH          = 10,
    parameter int INSTRUCTION_BITWIDTH      = 32,
    parameter int ICACHE_LINE_IX_BITWIDTH   = 1,
    parameter int CACHE_IX_IN_LINE_BITWIDTH = 3,
    parameter int RAM_DEPTH_BITWIDTH        = 4,
    parameter int RAM_BURST_DATA_COUNT      = 4,
    parameter int RAM_BURST_DATA_BITWIDTH   = 64
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [3:0]                           weA,
    input  logic [ADDRESS_BITWIDTH-1:0]          addrA,
    input  logic [INSTRUCTION_BITWIDTH-1:0]      dinA,
    output logic [INSTRUCTION_BITWIDTH-1:0]      doutA,
    input  logic [ADDRESS_BITWIDTH-1:0]          addrB,
    input  logic                                 enB,
    output logic [INSTRUCTION_BITWIDTH-1:0]      doutB,
    output logic                                 rdyB,
    output logic                                 bsyB,
    output logic                                 br_cmd,
    output logic                                 br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data,
    output logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_rd_data,
    input  logic                                 br_rd_data_valid,
    input  logic                                 br_busy
);

    localparam int LINES     = 2**ICACHE_LINE_IX_BITWIDTH;
    localparam int LINE_LSB  = 2 + CACHE_IX_IN_LINE_BITWIDTH;
    localparam int TAG_LSB   = LINE_LSB + ICACHE_LINE_IX_BITWIDTH;
    localparam int TAG_W     = ADDRESS_BITWIDTH - TAG_LSB;
    localparam int BEAT_IX_W = CACHE_IX_IN_LINE_BITWIDTH
                               - $clog2(RAM_BURST_DATA_BITWIDTH / INSTRUCTION_BITWIDTH);
    localparam int BEAT_SH   = $clog2(RAM_BURST_DATA_BITWIDTH / 8);

    if (RAM_BURST_DATA_COUNT * RAM_BURST_DATA_BITWIDTH !=
        (2**CACHE_IX_IN_LINE_BITWIDTH) * INSTRUCTION_BITWIDTH) begin : g_geometry_check
        $error("cache: burst size does not match line size");
    end

    state_t                             r_state, w_state_next;
    logic [ADDRESS_BITWIDTH-1:0]        r_addr;
    logic [BEAT_IX_W-1:0]               r_beat;
    logic [LINES-1:0]                   r_valid;
    logic [TAG_W-1:0]                   r_tag [LINES];
    logic [INSTRUCTION_BITWIDTH-1:0]    r_doutB;
    logic                               r_rdyB;
    logic                               r_bsyB;
    logic                               r_br_cmd_en;

    logic [ICACHE_LINE_IX_BITWIDTH-1:0]   w_line;
    logic [CACHE_IX_IN_LINE_BITWIDTH-1:0] w_word;
    logic [TAG_W-1:0]                     w_tag;
    logic                                 w_hit;
    logic                                 w_beat_we;
    logic                                 w_last_beat;
    logic [INSTRUCTION_BITWIDTH-1:0]      w_rd_word;
    logic                                 w_unused_ok;

    assign w_line      = r_addr[LINE_LSB +: ICACHE_LINE_IX_BITWIDTH];
    assign w_word      = r_addr[2 +: CACHE_IX_IN_LINE_BITWIDTH];
    assign w_tag       = r_addr[TAG_LSB +: TAG_W];
    assign w_hit       = r_valid[w_line] && (r_tag[w_line] == w_tag);
    assign w_beat_we   = (r_state == S_FILL) && br_rd_data_valid;
    assign w_last_beat = (r_beat == BEAT_IX_W'(RAM_BURST_DATA_COUNT - 1));
    assign w_unused_ok = ^{weA, addrA, dinA, r_addr[1:0]};

    cache_line_ram #(
        .LINE_IX_W (ICACHE_LINE_IX_BITWIDTH),
        .WORD_IX_W (CACHE_IX_IN_LINE_BITWIDTH),
        .WORD_W    (INSTRUCTION_BITWIDTH),
        .BEAT_W    (RAM_BURST_DATA_BITWIDTH)
    ) u_line_ram (
        .clk       (clk),
        .i_we      (w_beat_we),
        .i_wr_line (w_line),
        .i_wr_beat (r_beat),
        .i_wr_data (br_rd_data),
        .i_rd_line (w_line),
        .i_rd_word (w_word),
        .o_rd_data (w_rd_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (enB) w_state_next = S_LOOKUP;
            S_LOOKUP:  w_state_next = w_hit ? S_IDLE : S_REQ;
            S_REQ:     if (!br_busy) w_state_next = S_FILL;
            S_FILL:    if (w_beat_we && w_last_beat) w_state_next = S_DELIVER;
            S_DELIVER: w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_beat      <= '0;
            r_valid     <= '0;
            r_doutB     <= '0;
            r_rdyB      <= 1'b0;
            r_bsyB      <= 1'b0;
            r_br_cmd_en <= 1'b0;
        end else begin
            r_br_cmd_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enB) begin
                        r_addr <= addrB;
                        r_rdyB <= 1'b0;
                        r_bsyB <= 1'b1;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        r_doutB <= w_rd_word;
                        r_rdyB  <= 1'b1;
                        r_bsyB  <= 1'b0;
                    end else begin
                        // Line is invalid while it is being overwritten.
                        r_valid[w_line] <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (!br_busy) begin
                        r_br_cmd_en <= 1'b1;
                        r_beat      <= '0;
                    end
                end
                S_FILL: begin
                    if (w_beat_we) begin
                        r_beat <= r_beat + BEAT_IX_W'(1);
                        if (w_last_beat) begin
                            r_valid[w_line] <= 1'b1;
                        end
                    end
                end
                S_DELIVER: begin
                    r_doutB <= w_rd_word;
                    r_rdyB  <= 1'b1;
                    r_bsyB  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_beat_we && w_last_beat) begin
            r_tag[w_line] <= w_tag;
        end
    end

`ifdef CACHE_DBG_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == S_LOOKUP) begin
                $display("cache %s addr=%h line=%0d tag=%h", w_hit ? "hit " : "miss",
                         r_addr, w_line, w_tag);
            end
            if (w_beat_we && w_last_beat) begin
                $display("cache fill addr=%h line=%0d tag=%h", r_addr, w_line, w_tag);
            end
        end
    end
`endif

    assign doutB        = r_doutB;
    assign rdyB         = r_rdyB;
    assign bsyB         = r_bsyB;
    assign br_cmd_en    = r_br_cmd_en;
    assign br_cmd       = CMD_READ;
    assign br_addr      = RAM_DEPTH_BITWIDTH'(r_addr >> BEAT_SH)
                          & ~RAM_DEPTH_BITWIDTH'(RAM_BURST_DATA_COUNT - 1);
    assign br_wr_data   = '0;
    assign br_data_mask = '0;
    assign doutA        = '0;

endmodule

// File: tb/tb_cache.sv
// Scoreboard bench for cache: BurstRAM model, reference hit/miss model, randomized fetches.
module tb_cache;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  weA = '0;
    logic [9:0]  addrA = '0;
    logic [31:0] dinA = '0;
    logic [31:0] doutA;
    logic [9:0]  addrB = '0;
    logic        enB = 1'b0;
    logic [31:0] doutB;
    logic        rdyB, bsyB;
    logic        br_cmd, br_cmd_en;
    logic [3:0]  br_addr;
    logic [63:0] br_wr_data;
    logic [7:0]  br_data_mask;
    logic [63:0] br_rd_data = '0;
    logic        br_rd_data_valid = 1'b0;
    logic        br_busy = 1'b0;

    always #5 clk = ~clk;

    cache dut (
        .clk(clk), .rst(rst), .weA(weA), .addrA(addrA), .dinA(dinA), .doutA(doutA),
        .addrB(addrB), .enB(enB), .doutB(doutB), .rdyB(rdyB), .bsyB(bsyB),
        .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr),
        .br_wr_data(br_wr_data), .br_data_mask(br_data_mask),
        .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid), .br_busy(br_busy)
    );

    typedef struct {
        logic [31:0] data;
        bit          hit;
        int          issue;
        int          ncmd;
    } exp_t;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          n_cmd = 0;
    logic [63:0] mem [16];
    int          cmd_q[$];
    exp_t        expq[$];
    bit          lv [2];
    int          lt [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timeout at cycle %0d", name, cyc);
        finish_run();
    endtask

    function automatic logic [31:0] exp_word(input int a);
        logic [63:0] w;
        w = mem[(a / 8) % 16];
        return ((a / 4) % 2 == 1) ? w[63:32] : w[31:0];
    endfunction

    task automatic wait_idle();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (bsyB && t < 1000);
        if (bsyB) timeout("wait_idle");
    endtask

    // poke: second enB while busy; abort: reset during the fill.
    task automatic fetch(input int a, input bit poke, input bit abort);
        int   line, tag, t, n0;
        exp_t e;
        wait_idle();
        @(negedge clk);
        enB   = 1'b1;
        addrB = 10'(a);
        weA   = 4'($urandom);
        addrA = 10'($urandom);
        dinA  = $urandom;
        line  = (a / 32) % 2;
        tag   = a / 64;
        e.hit = lv[line] && (lt[line] == tag);
        if (!e.hit) begin
            lv[line] = 1'b1;
            lt[line] = tag;
            cmd_q.push_back(((a / 8) - ((a / 8) % 4)) % 16);
        end
        @(negedge clk);
        enB     = 1'b0;
        e.data  = exp_word(a);
        e.issue = cyc;
        e.ncmd  = n_cmd + (e.hit ? 0 : 1);
        expq.push_back(e);
        if (poke) begin
            repeat (2) @(negedge clk);
            check("busy_before_poke", bsyB, 1);
            enB   = 1'b1;
            addrB = 10'h3FC;
            @(negedge clk);
            enB = 1'b0;
        end
        if (abort) begin
            n0 = e.ncmd;
            t  = 0;
            while (n_cmd < n0 && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (n_cmd < n0) timeout("abort_burst");
            @(negedge clk);
            check("busy_in_fill", bsyB, 1);
            rst = 1'b1;
            repeat (3) @(negedge clk);
            rst = 1'b0;
            check("rst_fill_bsyB", bsyB, 0);
            check("rst_fill_rdyB", rdyB, 0);
            expq.delete();
            cmd_q.delete();
            lv[0] = 1'b0;
            lv[1] = 1'b0;
        end
    endtask

    // BurstRAM model: 3-cycle latency, 4 beats with random gaps, stray valids while idle.
    initial begin : burst_ram
        bit out;
        int delay, base, beat;
        out = 1'b0;
        forever begin
            @(negedge clk);
            br_rd_data_valid = 1'b0;
            if (rst) begin
                out     = 1'b0;
                br_busy = 1'b0;
            end else begin
                if (br_cmd_en) begin
                    n_cmd++;
                    check("br_cmd", br_cmd, 0);
                    check("br_wr_data", br_wr_data, 0);
                    check("br_data_mask", br_data_mask, 0);
                    if (cmd_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_burst: br_addr %0h, none expected", br_addr);
                    end else begin
                        check("br_addr", br_addr, cmd_q.pop_front());
                    end
                    out   = 1'b1;
                    base  = int'(br_addr);
                    delay = 3;
                    beat  = 0;
                end else if (out) begin
                    if (delay > 1) delay--;
                    else if ($urandom_range(0, 2) != 0) begin
                        br_rd_data_valid = 1'b1;
                        br_rd_data       = mem[(base + beat) % 16];
                        beat++;
                        if (beat == 4) out = 1'b0;
                    end
                end else if (!bsyB && $urandom_range(0, 3) == 0) begin
                    br_rd_data_valid = 1'b1;
                    br_rd_data       = {$urandom, $urandom};
                end
                br_busy = out ? 1'b1 : ($urandom_range(0, 2) == 0);
            end
        end
    end

    initial begin : monitor
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rdyB && !prev && !rst) begin
                if (expq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_rdyB: doutB %0h with nothing pending", doutB);
                end else begin
                    e = expq.pop_front();
                    check("doutB", doutB, e.data);
                    check("bsyB_done", bsyB, 0);
                    check("burst_count", n_cmd, e.ncmd);
                    if (e.hit) check("hit_latency", cyc - e.issue, 1);
                    check("doutA", doutA, 0);
                end
            end
            prev = rdyB;
        end
    end

    initial begin : stimulus
        int t;
        for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom};
        mem[0]        = 64'h3F5A2E14_B7C6A980;
        mem[1][31:0]  = 32'hAB4C3E6F;
        mem[4][31:0]  = 32'h2F5E3C7A;
        mem[8][31:0]  = 32'h4E5F6A7B;
        lv[0] = 1'b0;
        lv[1] = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_rdyB", rdyB, 0);
        check("reset_bsyB", bsyB, 0);
        check("reset_doutB", doutB, 0);
        check("reset_cmd_en", br_cmd_en, 0);
        check("reset_doutA", doutA, 0);
        rst = 1'b0;

        fetch(32'h000, 0, 0);
        fetch(32'h004, 0, 0);
        fetch(32'h008, 0, 0);
        fetch(32'h040, 0, 0);
        fetch(32'h020, 1, 0);
        fetch(32'h000, 0, 1);
        fetch(32'h000, 0, 0);
        fetch(32'h004, 0, 0);

        for (int i = 0; i < 60; i++) begin
            fetch($urandom_range(0, 127) * 4, 0, 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        t = 0;
        while ((expq.size() != 0 || bsyB) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (expq.size() != 0 || bsyB) timeout("drain");
        check("pending_bursts", cmd_q.size(), 0);
        finish_run();
    end

endmodule

// File: doc/cache.md
CACHE -- requirements
Module: cache

Interface
REQ-001 Parameters (default, meaning), SHALL be provided as follows:
- ADDRESS_BITWIDTH, 10: byte-address width of ports A and B.
- INSTRUCTION_BITWIDTH, 32: instruction and data word width.
- ICACHE_LINE_IX_BITWIDTH, 1: log2 of the number of lines (direct-mapped).
- CACHE_IX_IN_LINE_BITWIDTH, 3: log2 of the number of words per line.
- RAM_DEPTH_BITWIDTH, 4: BurstRAM word-address width.
- RAM_BURST_DATA_COUNT, 4: beats per burst.
- RAM_BURST_DATA_BITWIDTH, 64: bits per beat.
REQ-002 Ports (name, direction, width, meaning), SHALL be provided as follows:
- clk, in, 1: the single clock.
- rst, in, 1: reset; synchronous, active-high.
- weA, in, 4: port A byte write enables (reserved).
- addrA, in, ADDRESS_BITWIDTH: port A address (reserved).
- dinA, in, 32: port A write data (reserved).
- doutA, out, 32: port A read data.
- addrB, in, ADDRESS_BITWIDTH: instruction fetch byte address.
- enB, in, 1: one-cycle fetch request strobe.
- doutB, out, 32: fetched instruction.
- rdyB, out, 1: doutB valid.
- bsyB, out, 1: fetch in progress.
- br_cmd, out, 1: BurstRAM command, 0=read, 1=write.
- br_cmd_en, out, 1: BurstRAM command strobe.
- br_addr, out, RAM_DEPTH_BITWIDTH: BurstRAM word address.
- br_wr_data, out, 64: BurstRAM write data.
- br_data_mask, out, 8: BurstRAM byte mask.
- br_rd_data, in, 64: BurstRAM read beat.
- br_rd_data_valid, in, 1: read beat valid.
- br_busy, in, 1: BurstRAM cannot accept a command.

Function
REQ-003 Address split of addrB SHALL be: bits[1:0] ignored; next CACHE_IX_IN_LINE_BITWIDTH bits select the word in the line; next ICACHE_LINE_IX_BITWIDTH bits select the line; remaining upper bits form the tag. With defaults: word=[4:2], line=[5], tag=[9:6].
REQ-004 Storage SHALL be direct-mapped: per line, one valid bit, one tag and 2^CACHE_IX_IN_LINE_BITWIDTH words.
REQ-005 States SHALL be IDLE, LOOKUP, REQ, FILL and DELIVER.
REQ-006 IDLE: an enB sampled high SHALL latch addrB, clear rdyB, set bsyB and go to LOOKUP; enB SHALL be ignored in all other states.
REQ-007 LOOKUP, hit (valid and tag equal): doutB SHALL be loaded with the word, rdyB set, bsyB cleared and the state SHALL return to IDLE, so rdyB is high 2 edges after the enB edge.
REQ-008 LOOKUP, miss: SHALL go to REQ.
REQ-009 REQ: when br_busy is low, SHALL drive br_cmd=0, br_cmd_en=1 for exactly one cycle and br_addr=(byte address>>3) with its low log2(RAM_BURST_DATA_COUNT) bits zeroed, truncated to RAM_DEPTH_BITWIDTH, then go to FILL.
REQ-010 FILL: each br_rd_data_valid beat k (0..3) SHALL store two words: bits[31:0] to word 2k and bits[63:32] to word 2k+1 (little-endian). Beats SHALL be counted and need not be consecutive. After the last beat the tag SHALL be written, valid set and the state SHALL go to DELIVER.
REQ-011 DELIVER: doutB SHALL be loaded with the requested word, rdyB set, bsyB cleared and the state SHALL return to IDLE.
REQ-012 doutB and rdyB SHALL hold until the next accepted enB.
REQ-013 Port A SHALL be reserved: doutA=0; weA, addrA and dinA ignored. br_cmd SHALL never be 1; br_wr_data=0; br_data_mask=0.
REQ-014 br_rd_data_valid outside FILL SHALL be ignored.
REQ-015 RAM_BURST_DATA_COUNT*RAM_BURST_DATA_BITWIDTH SHALL equal 2^CACHE_IX_IN_LINE_BITWIDTH*INSTRUCTION_BITWIDTH, otherwise elaboration SHALL fail.

Reset
REQ-016 With rst high at an edge: state=IDLE, all valid bits=0, rdyB=0, bsyB=0, doutB=0, br_cmd_en=0, br_cmd=0, beat counter=0. Reset mid-FILL SHALL abandon the fill with the line invalid.

Configuration
REQ-017 With CACHE_DBG_EN defined, the simulation log SHALL print one line per hit, miss and completed fill (address, line, tag). Without it, nothing SHALL be printed. Port behaviour SHALL be identical in both cases.

Structure
REQ-018 Package cache_pkg SHALL hold the state enum and the BurstRAM command constants CMD_READ=0 and CMD_WRITE=1.
REQ-019 Line data storage SHALL be a sub-module cache_line_ram: one write port of one beat (two words), one word read port.

Verification (BurstRAM: CYCLES_BEFORE_DATA_READY=3, BURST_COUNT=4; word0={3F5A2E14,B7C6A980}, word1 low=AB4C3E6F, word4 low=2F5E3C7A, word8 low=4E5F6A7B)
REQ-020 Fetch 0x000 after reset -> miss, one br_cmd_en with br_addr=0, doutB=B7C6A980.
REQ-021 Fetch 0x004, then 0x008 -> hits, no br_cmd_en, rdyB 2 edges after enB, doutB=3F5A2E14 then AB4C3E6F.
REQ-022 Fetch 0x040 -> miss on line 0 (tag 1), br_addr=8, doutB=4E5F6A7B.
REQ-023 Fetch 0x020 -> miss on line 1, br_addr=4, doutB=2F5E3C7A; a second enB while bsyB is high -> ignored.
REQ-024 rst asserted during FILL -> bsyB=0, rdyB=0; refetching 0x000 -> miss with a new burst.
